// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_pkg
// Description : Shared Ufop codes, tag constants and dispatch FSM encoding.
// Revision    : 1.0
// ============================================================================
package tomasulo_pkg;

    localparam logic [2:0] UFOP_NOP = 3'b000;
    localparam logic [2:0] UFOP_ADD = 3'b010;
    localparam logic [2:0] UFOP_SUB = 3'b011;
    localparam logic [2:0] UFOP_SLT = 3'b110;
    localparam logic [2:0] UFOP_CMP = 3'b111;

    localparam int TAG_NONE      = 0;
    localparam int DEFAULT_TAG_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } disp_state_t;

    // Only ops the unit will ever complete are worth holding an entry for.
    function automatic logic op_is_valid(input logic [2:0] op);
        logic v;
        case (op)
            UFOP_ADD, UFOP_SUB, UFOP_SLT, UFOP_CMP: v = 1'b1;
            UFOP_NOP:                               v = 1'b0;
            default:                                v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/entrada_estacao_r.sv
`default_nettype none
// ============================================================================
// Module      : entrada_estacao_r
// Description : One reservation-station entry with its own CDB snoop.
// Revision    : 1.0
// ============================================================================
module entrada_estacao_r
    import tomasulo_pkg::*;
#(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_alloc,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [DATA_W-1:0] i_vk,
    input  logic [TAG_W-1:0]  i_qj,
    input  logic [TAG_W-1:0]  i_qk,
    input  logic [TAG_W-1:0]  i_dest,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_dispatch,
    input  logic              i_free,
    output logic              o_busy,
    output logic              o_ready,
    output logic [2:0]        o_op,
    output logic [DATA_W-1:0] o_vj,
    output logic [DATA_W-1:0] o_vk,
    output logic [TAG_W-1:0]  o_dest
);

    localparam logic [TAG_W-1:0] c_TAG_NONE = TAG_W'(TAG_NONE);

    logic              r_busy;
    logic              r_exec;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_vj;
    logic [DATA_W-1:0] r_vk;
    logic [TAG_W-1:0]  r_qj;
    logic [TAG_W-1:0]  r_qk;
    logic [TAG_W-1:0]  r_dest;

    logic w_hit_j_in;
    logic w_hit_k_in;
    logic w_hit_j;
    logic w_hit_k;

    // Issue-side hits forward a broadcast landing in the same cycle.
    assign w_hit_j_in = i_cdb_valid && (i_qj != c_TAG_NONE) && (i_qj == i_cdb_tag);
    assign w_hit_k_in = i_cdb_valid && (i_qk != c_TAG_NONE) && (i_qk == i_cdb_tag);
    assign w_hit_j    = i_cdb_valid && r_busy && (r_qj != c_TAG_NONE) && (r_qj == i_cdb_tag);
    assign w_hit_k    = i_cdb_valid && r_busy && (r_qk != c_TAG_NONE) && (r_qk == i_cdb_tag);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
            r_exec <= 1'b0;
            r_op   <= '0;
            r_vj   <= '0;
            r_vk   <= '0;
            r_qj   <= '0;
            r_qk   <= '0;
            r_dest <= '0;
        end else if (i_alloc) begin
            r_busy <= 1'b1;
            r_exec <= 1'b0;
            r_op   <= i_op;
            r_dest <= i_dest;
            r_vj   <= w_hit_j_in ? i_cdb_data : i_vj;
            r_qj   <= w_hit_j_in ? c_TAG_NONE : i_qj;
            r_vk   <= w_hit_k_in ? i_cdb_data : i_vk;
            r_qk   <= w_hit_k_in ? c_TAG_NONE : i_qk;
        end else begin
            if (i_free) begin
                r_busy <= 1'b0;
                r_exec <= 1'b0;
            end else if (i_dispatch) begin
                r_exec <= 1'b1;
            end
            if (w_hit_j) begin
                r_vj <= i_cdb_data;
                r_qj <= c_TAG_NONE;
            end
            if (w_hit_k) begin
                r_vk <= i_cdb_data;
                r_qk <= c_TAG_NONE;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy && !r_exec && (r_qj == c_TAG_NONE) && (r_qk == c_TAG_NONE);
    assign o_op    = r_op;
    assign o_vj    = r_vj;
    assign o_vk    = r_vk;
    assign o_dest  = r_dest;

endmodule
`default_nettype wire

// File: rtl/estacao_reserva_r.sv
`default_nettype none
// ============================================================================
// Module      : estacao_reserva_r
// Description : R-type reservation station: issue, CDB snoop, dispatch FSM.
// Revision    : 1.0
// ============================================================================
module estacao_reserva_r
    import tomasulo_pkg::*;
#(
    parameter int N_ENTRIES = 3,
    parameter int TAG_W     = DEFAULT_TAG_W,
    parameter int DATA_W    = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Issue_valid,
    output logic              Issue_ready,
    input  logic [2:0]        Issue_op,
    input  logic [DATA_W-1:0] Issue_vj,
    input  logic [DATA_W-1:0] Issue_vk,
    input  logic [TAG_W-1:0]  Issue_qj,
    input  logic [TAG_W-1:0]  Issue_qk,
    input  logic [TAG_W-1:0]  Issue_dest_tag,
    input  logic              CDB_valid,
    input  logic [TAG_W-1:0]  CDB_tag,
    input  logic [DATA_W-1:0] CDB_data,
    output logic [DATA_W-1:0] Uf_op1,
    output logic [DATA_W-1:0] Uf_op2,
    output logic [2:0]        Uf_ufop,
    output logic              Ready_to_uf,
    output logic              Uf_clear,
    input  logic              Uf_done,
    input  logic              Uf_write_enable_cdb,
    output logic              Result_valid,
    output logic [TAG_W-1:0]  Result_tag,
    output logic [2:0]        Busy_count
);

    localparam int c_IDX_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0] w_busy;
    logic [N_ENTRIES-1:0] w_ready;
    logic [N_ENTRIES-1:0] w_alloc;
    logic [N_ENTRIES-1:0] w_dispatch_vec;
    logic [N_ENTRIES-1:0] w_free_vec;
    logic [2:0]           w_ent_op   [N_ENTRIES];
    logic [DATA_W-1:0]    w_ent_vj   [N_ENTRIES];
    logic [DATA_W-1:0]    w_ent_vk   [N_ENTRIES];
    logic [TAG_W-1:0]     w_ent_dest [N_ENTRIES];

    logic                 w_free_any;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic                 w_ready_any;
    logic [c_IDX_W-1:0]   w_ready_idx;
    logic [2:0]           w_busy_count;
    logic                 w_issue_write;
    logic                 w_dispatch;
    logic                 w_complete;

    disp_state_t          r_state;
    disp_state_t          w_state_nxt;
    logic [c_IDX_W-1:0]   r_sel;

    // Descending scan leaves the lowest matching index selected.
    always_comb begin
        w_free_any   = 1'b0;
        w_free_idx   = '0;
        w_ready_any  = 1'b0;
        w_ready_idx  = '0;
        w_busy_count = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_free_any = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_ready_any = 1'b1;
                w_ready_idx = c_IDX_W'(i);
            end
            w_busy_count = w_busy_count + 3'(w_busy[i]);
        end
    end

    assign Issue_ready   = w_free_any;
    assign Busy_count    = w_busy_count;
    assign w_issue_write = Issue_valid && w_free_any && op_is_valid(Issue_op);

    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
        assign w_alloc[gi]        = w_issue_write && (w_free_idx == c_IDX_W'(gi));
        assign w_dispatch_vec[gi] = w_dispatch && (w_ready_idx == c_IDX_W'(gi));
        assign w_free_vec[gi]     = w_complete && (r_sel == c_IDX_W'(gi));

        entrada_estacao_r #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_entry (
            .Clock       (Clock),
            .Reset       (Reset),
            .i_alloc     (w_alloc[gi]),
            .i_op        (Issue_op),
            .i_vj        (Issue_vj),
            .i_vk        (Issue_vk),
            .i_qj        (Issue_qj),
            .i_qk        (Issue_qk),
            .i_dest      (Issue_dest_tag),
            .i_cdb_valid (CDB_valid),
            .i_cdb_tag   (CDB_tag),
            .i_cdb_data  (CDB_data),
            .i_dispatch  (w_dispatch_vec[gi]),
            .i_free      (w_free_vec[gi]),
            .o_busy      (w_busy[gi]),
            .o_ready     (w_ready[gi]),
            .o_op        (w_ent_op[gi]),
            .o_vj        (w_ent_vj[gi]),
            .o_vk        (w_ent_vk[gi]),
            .o_dest      (w_ent_dest[gi])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ready_any) begin
                    w_dispatch  = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // CMP only ever raises the CDB write enable, never Done.
                if (Uf_done || Uf_write_enable_cdb) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            Uf_op1       <= '0;
            Uf_op2       <= '0;
            Uf_ufop      <= '0;
            Ready_to_uf  <= 1'b0;
            Uf_clear     <= 1'b0;
            Result_valid <= 1'b0;
            Result_tag   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            Uf_clear     <= w_complete;
            Result_valid <= w_complete;
            if (w_dispatch) begin
                r_sel       <= w_ready_idx;
                Uf_op1      <= w_ent_vj[w_ready_idx];
                Uf_op2      <= w_ent_vk[w_ready_idx];
                Uf_ufop     <= w_ent_op[w_ready_idx];
                Ready_to_uf <= 1'b1;
            end
            if (w_complete) begin
                Ready_to_uf <= 1'b0;
                Result_tag  <= w_ent_dest[r_sel];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_estacao_reserva_r.sv
`default_nettype none
// ============================================================================
// Module      : tb_estacao_reserva_r
// Description : Directed, table-driven bench with a small R-type unit model.
// Revision    : 1.0
// ============================================================================
module tb_estacao_reserva_r;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Issue_valid;
    logic        Issue_ready;
    logic [2:0]  Issue_op;
    logic [15:0] Issue_vj, Issue_vk;
    logic [2:0]  Issue_qj, Issue_qk, Issue_dest_tag;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic [15:0] Uf_op1, Uf_op2;
    logic [2:0]  Uf_ufop;
    logic        Ready_to_uf, Uf_clear;
    logic        Uf_done, Uf_write_enable_cdb;
    logic        Result_valid;
    logic [2:0]  Result_tag;
    logic [2:0]  Busy_count;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    estacao_reserva_r #(.N_ENTRIES(3), .TAG_W(3), .DATA_W(16)) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .Issue_valid         (Issue_valid),
        .Issue_ready         (Issue_ready),
        .Issue_op            (Issue_op),
        .Issue_vj            (Issue_vj),
        .Issue_vk            (Issue_vk),
        .Issue_qj            (Issue_qj),
        .Issue_qk            (Issue_qk),
        .Issue_dest_tag      (Issue_dest_tag),
        .CDB_valid           (CDB_valid),
        .CDB_tag             (CDB_tag),
        .CDB_data            (CDB_data),
        .Uf_op1              (Uf_op1),
        .Uf_op2              (Uf_op2),
        .Uf_ufop             (Uf_ufop),
        .Ready_to_uf         (Ready_to_uf),
        .Uf_clear            (Uf_clear),
        .Uf_done             (Uf_done),
        .Uf_write_enable_cdb (Uf_write_enable_cdb),
        .Result_valid        (Result_valid),
        .Result_tag          (Result_tag),
        .Busy_count          (Busy_count)
    );

    // Unit model: Tstep advances one edge after dispatch, Q/Done the edge after.
    logic [1:0]  m_step;
    logic [15:0] m_q;
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_step <= 2'd0; m_q <= 16'd0;
            Uf_done <= 1'b0; Uf_write_enable_cdb <= 1'b0;
        end else if (Uf_clear) begin
            m_step <= 2'd0;
            Uf_done <= 1'b0; Uf_write_enable_cdb <= 1'b0;
        end else if (Ready_to_uf) begin
            if (m_step == 2'd0) m_step <= 2'd1;
            else if (m_step == 2'd1) begin
                m_step <= 2'd2;
                case (Uf_ufop)
                    3'b010:  m_q <= Uf_op1 + Uf_op2;
                    3'b011:  m_q <= Uf_op1 - Uf_op2;
                    3'b110:  m_q <= ($signed(Uf_op1) < $signed(Uf_op2)) ? 16'd1 : 16'd0;
                    default: m_q <= (Uf_op1 == Uf_op2) ? 16'd1 : 16'd0;
                endcase
                if (Uf_ufop == 3'b111) Uf_write_enable_cdb <= 1'b1;
                else                   Uf_done <= 1'b1;
            end
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] vj, vk;
        logic [2:0]  dest;
        logic [15:0] exp_q;
    } vec_t;
    vec_t vecs[6];

    task automatic step();
        @(posedge Clock); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] dest);
        Issue_valid = 1'b1; Issue_op = op; Issue_vj = vj; Issue_vk = vk;
        Issue_qj = qj; Issue_qk = qk; Issue_dest_tag = dest;
        step();
        Issue_valid = 1'b0; Issue_op = 3'd0; Issue_vj = 16'd0; Issue_vk = 16'd0;
        Issue_qj = 3'd0; Issue_qk = 3'd0; Issue_dest_tag = 3'd0;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
        CDB_valid = 1'b1; CDB_tag = tag; CDB_data = data;
        step();
        CDB_valid = 1'b0; CDB_tag = 3'd0; CDB_data = 16'd0;
    endtask

    // Waits (bounded) for the result pulse, checks it and the one-cycle clear.
    task automatic wait_result(input string name, input logic [2:0] tag,
                               input logic [15:0] q, output int n);
        n = 0;
        while (!Result_valid && n < 20) begin
            step(); n++;
        end
        check({name, " result_valid"}, Result_valid, 1);
        check({name, " result_tag"}, Result_tag, tag);
        check({name, " unit_q"}, m_q, q);
        check({name, " clear_hi"}, Uf_clear, 1);
        step();
        check({name, " clear_lo"}, {Uf_clear, Result_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        logic seen;
        vecs[0] = '{"add_5_7",   3'b010, 16'd5,      16'd7, 3'd3, 16'd12};
        vecs[1] = '{"sub_20_8",  3'b011, 16'd20,     16'd8, 3'd1, 16'd12};
        vecs[2] = '{"slt_3_9",   3'b110, 16'd3,      16'd9, 3'd6, 16'd1};
        vecs[3] = '{"slt_neg",   3'b110, 16'hFFFF,   16'd1, 3'd7, 16'd1};
        vecs[4] = '{"add_wrap",  3'b010, 16'hFFFF,   16'd2, 3'd2, 16'd1};
        vecs[5] = '{"cmp_9_9",   3'b111, 16'd9,      16'd9, 3'd4, 16'd1};

        Reset = 1'b1; Issue_valid = 1'b0; Issue_op = 3'd0; Issue_vj = 16'd0; Issue_vk = 16'd0;
        Issue_qj = 3'd0; Issue_qk = 3'd0; Issue_dest_tag = 3'd0;
        CDB_valid = 1'b0; CDB_tag = 3'd0; CDB_data = 16'd0;
        #1;
        check("reset outputs", {Ready_to_uf, Uf_clear, Result_valid, Result_tag, Uf_ufop, Uf_op1, Uf_op2}, 0);
        check("reset issue_ready", Issue_ready, 1);
        check("reset busy_count", Busy_count, 0);
        #11 Reset = 1'b0;
        step();

        // Ready operands: latency counts edges from the issuing edge inclusive.
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].op, vecs[v].vj, vecs[v].vk, 3'd0, 3'd0, vecs[v].dest);
            check({vecs[v].name, " busy_count"}, Busy_count, 1);
            step();
            check({vecs[v].name, " dispatch"}, Ready_to_uf, 1);
            check({vecs[v].name, " op1"}, Uf_op1, vecs[v].vj);
            check({vecs[v].name, " op2"}, Uf_op2, vecs[v].vk);
            check({vecs[v].name, " ufop"}, Uf_ufop, vecs[v].op);
            wait_result(vecs[v].name, vecs[v].dest, vecs[v].exp_q, n);
            check({vecs[v].name, " latency"}, n + 2, 5);
            check({vecs[v].name, " freed"}, {Issue_ready, Busy_count}, {1'b1, 3'd0});
        end

        // Dropped ops never occupy an entry.
        issue(3'b000, 16'd1, 16'd1, 3'd0, 3'd0, 3'd1);
        check("nop busy_count", Busy_count, 0);
        issue(3'b101, 16'd1, 16'd1, 3'd0, 3'd0, 3'd1);
        step();
        check("undef op dropped", {Ready_to_uf, Busy_count}, 0);

        // Dependent SUB waits on tag 2, dispatches the edge after the CDB.
        issue(3'b011, 16'd0, 16'd4, 3'd2, 3'd0, 3'd5);
        step(); step();
        check("dep waits", Ready_to_uf, 0);
        cdb(3'd2, 16'd10);
        check("dep not same edge", Ready_to_uf, 0);
        step();
        check("dep dispatch", Ready_to_uf, 1);
        check("dep op1", Uf_op1, 16'd10);
        wait_result("dep_sub", 3'd5, 16'd6, n);

        // Same-cycle forwarding on issue.
        CDB_valid = 1'b1; CDB_tag = 3'd4; CDB_data = 16'd8;
        issue(3'b010, 16'd0, 16'd1, 3'd4, 3'd0, 3'd6);
        CDB_valid = 1'b0; CDB_tag = 3'd0; CDB_data = 16'd0;
        step();
        check("fwd dispatch", Ready_to_uf, 1);
        check("fwd op1", Uf_op1, 16'd8);
        wait_result("fwd_add", 3'd6, 16'd9, n);

        // Full station, fourth issue ignored, then in-order drain.
        for (int i = 0; i < 3; i++)
            issue(3'b010, 16'd0, 16'(i + 1), 3'd5, 3'd0, 3'(i + 1));
        check("full busy_count", Busy_count, 3);
        check("full issue_ready", Issue_ready, 0);
        issue(3'b010, 16'd1, 16'd1, 3'd0, 3'd0, 3'd7);
        check("full ignored", Busy_count, 3);
        step();
        check("full no dispatch", Ready_to_uf, 0);
        cdb(3'd5, 16'd100);
        for (int i = 0; i < 3; i++) begin
            wait_result($sformatf("drain%0d", i), 3'(i + 1), 16'(101 + i), n);
            check($sformatf("drain%0d busy", i), Busy_count, 3'(2 - i));
        end

        // Asynchronous reset while executing.
        issue(3'b010, 16'd1, 16'd1, 3'd0, 3'd0, 3'd2);
        step();
        check("rst exec dispatched", Ready_to_uf, 1);
        #2 Reset = 1'b1;
        #1;
        check("rst exec ready_to_uf", Ready_to_uf, 0);
        check("rst exec state", {Issue_ready, Busy_count, Uf_op1}, {1'b1, 3'd0, 16'd0});
        #2 Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | Result_valid | Ready_to_uf;
        end
        check("rst exec no result", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
